// File: rtl/piso_tx.sv
// piso_tx -- parallel-in / serial-out transmitter.
//
// Captures a WIDTH-bit word when load is seen while idle and shifts it out one
// bit per clock. frame is high for exactly WIDTH cycles while sout carries
// data. done pulses for one cycle after the last bit, then the block is ready.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous reset, active-high
//   load   transmit request, accepted only while ready=1
//   d      parallel word, sampled on the accepting edge
//   ready  1 = idle, the next load is accepted
//   frame  1 while sout carries a valid data bit
//   sout   serial data, forced to 0 outside frame
//   done   one-cycle pulse after the last bit
//
// Parameters:
//   WIDTH      bits per word (1..32)
//   LSB_FIRST  1: bit 0 goes out first, 0: bit WIDTH-1 goes out first
module piso_tx #(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic             ready,
   output logic             frame,
   output logic             sout,
   output logic             done
);

   // cnt must be able to hold WIDTH-1 and its increment without wrapping.
   localparam int             CW   = (WIDTH < 2) ? 1 : $clog2(WIDTH + 1);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
   localparam int             OUTB = LSB_FIRST ? 0 : WIDTH - 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] shreg, shreg_nxt;
   logic [CW-1:0]    cnt,   cnt_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         shreg <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         shreg <= shreg_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      shreg_nxt = shreg;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (load) begin
               shreg_nxt = d;
               cnt_nxt   = '0;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            // Move the next bit toward the output end, zero-filling behind it.
            shreg_nxt = LSB_FIRST ? (shreg >> 1) : (shreg << 1);
            cnt_nxt   = cnt + CW'(1);
            if (cnt == LAST) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs depend only on registered state, never on load or d directly.
   assign ready = (state == IDLE);
   assign frame = (state == SHIFT);
   assign done  = (state == DONE);
   assign sout  = frame & shreg[OUTB];

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx -- scoreboard bench for piso_tx.
// Three instances share clk/rst: 8-bit LSB-first, 8-bit MSB-first (same load/d)
// and a 1-bit instance with its own load. Expected bits are queued when a word
// is driven and popped on every frame cycle.
module tb_piso_tx;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst, load, load1, d1;
   logic [W-1:0] d;
   logic         rdy_l, frm_l, so_l, dn_l;
   logic         rdy_m, frm_m, so_m, dn_m;
   logic         rdy_1, frm_1, so_1, dn_1;
   logic [2:0]   rdy, frm, so, dn;

   always #5 clk = ~clk;

   piso_tx #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
      .clk(clk), .rst(rst), .load(load), .d(d),
      .ready(rdy_l), .frame(frm_l), .sout(so_l), .done(dn_l));
   piso_tx #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
      .clk(clk), .rst(rst), .load(load), .d(d),
      .ready(rdy_m), .frame(frm_m), .sout(so_m), .done(dn_m));
   piso_tx #(.WIDTH(1), .LSB_FIRST(1'b1)) u_w1 (
      .clk(clk), .rst(rst), .load(load1), .d(d1),
      .ready(rdy_1), .frame(frm_1), .sout(so_1), .done(dn_1));

   assign rdy = {rdy_1, rdy_m, rdy_l};
   assign frm = {frm_1, frm_m, frm_l};
   assign so  = {so_1,  so_m,  so_l};
   assign dn  = {dn_1,  dn_m,  dn_l};

   int    errs   = 0;
   int    checks = 0;
   int    cyc    = 0;
   bit    q[3][$];
   int    dcnt[3] = '{0, 0, 0};
   bit    pf[3]   = '{0, 0, 0};
   bit    pd[3]   = '{0, 0, 0};
   int    starts[$];
   string nm[3] = '{"lsb", "msb", "w1"};

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Monitor: compares every frame bit against the scoreboard and checks the
   // frame -> done -> ready ordering.
   always @(negedge clk) begin
      cyc++;
      for (int k = 0; k < 3; k++) begin
         if (rst) begin
            pf[k] = 1'b0;
            pd[k] = 1'b0;
         end else begin
            if (frm[k]) begin
               chk({nm[k], "_q_has_bit"}, 32'(q[k].size() != 0), 1);
               if (q[k].size() != 0) chk({nm[k], "_sout"}, 32'(so[k]), 32'(q[k].pop_front()));
               if (k == 0 && !pf[0]) starts.push_back(cyc);
            end else begin
               chk({nm[k], "_sout_idle"}, 32'(so[k]), 0);
            end
            if (pf[k] && !frm[k]) chk({nm[k], "_done_after_frame"}, 32'(dn[k]), 1);
            if (dn[k]) begin
               dcnt[k]++;
               chk({nm[k], "_done_prev_frame"}, 32'(pf[k]), 1);
            end
            if (pd[k]) chk({nm[k], "_ready_after_done"}, 32'(rdy[k]), 1);
            pf[k] = frm[k];
            pd[k] = dn[k];
         end
      end
   end

   task automatic send8(input logic [W-1:0] w);
      @(negedge clk);
      load = 1'b1;
      d    = w;
      for (int i = 0; i < W; i++) begin
         q[0].push_back(w[i]);
         q[1].push_back(w[W-1-i]);
      end
      @(negedge clk);
      load = 1'b0;
      d    = W'($urandom);
   endtask

   task automatic idle_check(input string tag, input int exp_done);
      chk({tag, "_ready_l"}, 32'(rdy_l), 1);
      chk({tag, "_ready_m"}, 32'(rdy_m), 1);
      chk({tag, "_qempty"}, 32'(q[0].size() + q[1].size()), 0);
      chk({tag, "_dcnt_l"}, 32'(dcnt[0]), 32'(exp_done));
      chk({tag, "_dcnt_m"}, 32'(dcnt[1]), 32'(exp_done));
   endtask

   task automatic rst_outputs(input string tag);
      chk({tag, "_outs_l"}, {28'd0, rdy_l, frm_l, so_l, dn_l}, 32'h8);
      chk({tag, "_outs_m"}, {28'd0, rdy_m, frm_m, so_m, dn_m}, 32'h8);
      chk({tag, "_outs_1"}, {28'd0, rdy_1, frm_1, so_1, dn_1}, 32'h8);
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; load1 = 1'b0; d = '0; d1 = 1'b0;
      #3;
      rst_outputs("reset");
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;

      // LSB/MSB order of A5 and 80
      send8(8'hA5);
      repeat (9) @(negedge clk);
      idle_check("a5", 1);
      send8(8'h80);
      repeat (9) @(negedge clk);
      idle_check("h80", 2);

      // load of FF during the 3rd frame cycle of 00 is ignored
      send8(8'h00);
      repeat (2) @(negedge clk);
      load = 1'b1;
      d    = 8'hFF;
      @(negedge clk);
      load = 1'b0;
      repeat (10) @(negedge clk);
      idle_check("busy_load", 3);

      // continuous load: accepts land every WIDTH+2 cycles
      starts.delete();
      @(negedge clk);
      load = 1'b1;
      d    = 8'h3C;
      for (int n = 0; n < 3; n++)
         for (int i = 0; i < W; i++) begin
            q[0].push_back(d[i]);
            q[1].push_back(d[W-1-i]);
         end
      repeat (21) @(negedge clk);
      load = 1'b0;
      repeat (12) @(negedge clk);
      idle_check("hold", 6);
      chk("hold_starts", 32'(starts.size()), 3);
      if (starts.size() == 3) begin
         chk("hold_gap1", 32'(starts[1] - starts[0]), 10);
         chk("hold_gap2", 32'(starts[2] - starts[1]), 10);
      end

      // reset in frame cycle 4 aborts the word with no done pulse
      send8(8'hC3);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      q[0].delete();
      q[1].delete();
      #1 rst_outputs("abort");
      @(negedge clk);
      #1 rst = 1'b0;
      repeat (10) @(negedge clk);
      idle_check("abort", 6);
      send8(8'h5A);
      repeat (9) @(negedge clk);
      idle_check("post_abort", 7);

      // WIDTH=1: one frame cycle per word
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         load1 = 1'b1;
         d1    = (i == 0);
         q[2].push_back(d1);
         @(negedge clk);
         load1 = 1'b0;
         repeat (3) @(negedge clk);
         chk("w1_ready", 32'(rdy_1), 1);
         chk("w1_dcnt", 32'(dcnt[2]), 32'(i + 1));
         chk("w1_qempty", 32'(q[2].size()), 0);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
